// File: rtl/dshim_pkg.sv
// Shared types and helpers for the byte-serial data-memory shim.
// Helpers work on a fixed maximum width; callers cast to their own word width.
package dshim_pkg;

  localparam int unsigned MAX_BYTES = 32;
  localparam int unsigned MAX_W     = 8 * MAX_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word lane that RAM byte slot i maps onto.
  function automatic int unsigned lane_sel(input int unsigned i,
                                           input int unsigned size,
                                           input logic        big_endian);
    return big_endian ? (size - i) : i;
  endfunction

  // Zero- or sign-fill every byte above the accessed field (size+1 bytes).
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] word,
                                              input int unsigned      size,
                                              input logic             signext);
    logic [MAX_W-1:0] res;
    logic             fill;
    res  = word;
    fill = signext & word[8*size+7];
    for (int unsigned b = 0; b < MAX_BYTES; b++) begin
      if (b > size) res[8*b +: 8] = {8{fill}};
    end
    return res;
  endfunction

endpackage

// File: rtl/dshim_slot_timer.sv
// Paces each RAM byte slot: slot_last marks the final of RAM_LAT+1 cycles.
module dshim_slot_timer #(
  parameter int unsigned RAM_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  output logic slot_last
);

  localparam int unsigned CW = 4;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (reload) cnt <= '0;
    else             cnt <= cnt + CW'(1);
  end

  assign slot_last = (cnt == CW'(RAM_LAT));

endmodule

// File: rtl/dshim_param.sv
// Word-to-byte data-memory shim: serialises one CPU word access into byte
// slots on the shared RAM port and returns the assembled word with a done pulse.
module dshim_param
  import dshim_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned BIG_ENDIAN = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic                           DMemWrite,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [$clog2(WORD_BYTES)-1:0]  size,
  input  logic                           signext,
  input  logic [8*WORD_BYTES-1:0]        data_in,
  input  logic [7:0]                     data_from_RAM,
  output logic                           RAMuse,
  output logic [ADDR_W-1:0]              RAMaddr,
  output logic [7:0]                     data_to_RAM,
  output logic                           RAMwrite,
  output logic                           RAMread,
  output logic                           done,
  output logic                           busy,
  output logic [8*WORD_BYTES-1:0]        data_out
);

  localparam int unsigned DW   = 8 * WORD_BYTES;
  localparam int unsigned SW   = $clog2(WORD_BYTES);
  localparam logic        BE_C = (BIG_ENDIAN != 0);

  state_t            state;
  logic              wr_l;
  logic              sx_l;
  logic [SW-1:0]     size_l;
  logic [DW-1:0]     data_l;
  logic [DW-1:0]     asm_q;
  logic [SW-1:0]     idx;

  logic [SW-1:0]     lane0;
  logic [SW-1:0]     lane_cur;
  logic [SW-1:0]     lane_nxt;
  logic [DW-1:0]     asm_next;
  logic              slot_last;
  logic              reload;

  // Lane steering and the read word with the current slot's byte merged in.
  always_comb begin
    lane0    = SW'(lane_sel(32'd0, 32'(size), BE_C));
    lane_cur = SW'(lane_sel(32'(idx), 32'(size_l), BE_C));
    lane_nxt = SW'(lane_sel(32'(idx) + 32'd1, 32'(size_l), BE_C));
    asm_next = asm_q;
    asm_next[8*lane_cur +: 8] = data_from_RAM;
  end

  assign reload = (state != XFER) || slot_last;

  dshim_slot_timer #(
    .RAM_LAT (RAM_LAT)
  ) u_slot_timer (
    .clk       (clk),
    .reset     (reset),
    .reload    (reload),
    .slot_last (slot_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_l        <= 1'b0;
      sx_l        <= 1'b0;
      size_l      <= '0;
      data_l      <= '0;
      asm_q       <= '0;
      idx         <= '0;
      RAMuse      <= 1'b0;
      RAMaddr     <= '0;
      data_to_RAM <= '0;
      RAMwrite    <= 1'b0;
      RAMread     <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      data_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            wr_l        <= DMemWrite;
            sx_l        <= signext;
            size_l      <= size;
            data_l      <= data_in;
            asm_q       <= '0;
            idx         <= '0;
            state       <= XFER;
            busy        <= 1'b1;
            RAMuse      <= 1'b1;
            RAMaddr     <= addr;
            RAMread     <= ~DMemWrite;
            RAMwrite    <= DMemWrite;
            data_to_RAM <= DMemWrite ? data_in[8*lane0 +: 8] : 8'h00;
          end
        end
        XFER: begin
          if (slot_last) begin
            if (!wr_l) asm_q <= asm_next;
            if (idx == size_l) begin
              // Last slot: release the RAM port and publish the read word.
              state       <= DONE;
              done        <= 1'b1;
              RAMuse      <= 1'b0;
              RAMread     <= 1'b0;
              RAMwrite    <= 1'b0;
              RAMaddr     <= '0;
              data_to_RAM <= '0;
              if (!wr_l) data_out <= DW'(extend(MAX_W'(asm_next), 32'(size_l), sx_l));
            end else begin
              idx         <= idx + SW'(1);
              RAMaddr     <= RAMaddr + ADDR_W'(1);
              data_to_RAM <= wr_l ? data_l[8*lane_nxt +: 8] : 8'h00;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dshim_param.md
Name: dshim_param

Overview:
- Parametrised successor to the fixed 32-bit data-memory shim: turns one word-level data-memory request into a sequence of byte-wide RAM accesses, then returns one assembled word with a single-cycle done pulse.
- New over the fixed shim:
  - configurable word width;
  - configurable RAM wait states;
  - per-request access size (1..WORD_BYTES bytes) with optional sign extension;
  - selectable endianness;
  - busy indication.
- Sits between the Y86 memory stage and the shared byte-wide RAM port.

Parameters:
- WORD_BYTES, 4, bytes per CPU word (power of 2, >=2)
- ADDR_W, 32, address width
- RAM_LAT, 1, wait cycles per byte slot (0..15)
- BIG_ENDIAN, 0, 0 = byte i at addr+i is bits [8i+7:8i]; 1 = byte i goes to the most-significant end of the accessed field

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe, sampled only in IDLE
- DMemWrite  in  1  1 = write, 0 = read; latched with req
- addr  in  ADDR_W  base byte address; latched
- size  in  $clog2(WORD_BYTES)  byte count minus 1; latched
- signext  in  1  sign-extend read result; latched
- data_in  in  8*WORD_BYTES  write data, low size+1 bytes used; latched
- data_from_RAM  in  8  RAM read byte
- RAMuse  out  1  shim owns RAM port
- RAMaddr  out  ADDR_W  current byte address
- data_to_RAM  out  8  current write byte
- RAMwrite  out  1  write strobe
- RAMread  out  1  read strobe
- done  out  1  one-cycle completion pulse
- busy  out  1  high from acceptance through the done cycle
- data_out  out  8*WORD_BYTES  assembled read word

Behaviour:
- Reset (asynchronous, any state): state IDLE; all outputs 0, including data_out; byte index and wait counter cleared. Reset mid-transfer aborts with no done pulse.
- States: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - req=1 at a rising edge latches DMemWrite, addr, size, signext and data_in.
  - Sets byte index i=0 and wait count 0, then enters XFER.
- XFER, byte slot i:
  - Each slot lasts RAM_LAT+1 cycles.
  - Throughout the slot: RAMuse=1; RAMaddr=addr_l+i (wraps modulo 2^ADDR_W); RAMread=!wr_l; RAMwrite=wr_l.
  - data_to_RAM = lane(i) of data_l; 0 on reads.
  - Read: data_from_RAM is sampled on the last cycle of the slot into lane(i) of the shift/assemble register.
  - After slot i=size, go to DONE; otherwise i++ and the wait count reloads.
- lane(i): i when BIG_ENDIAN=0; size-i when BIG_ENDIAN=1.
- DONE (one cycle):
  - done=1, busy=1; strobes and RAMuse are 0.
  - On a read, data_out updates at entry to DONE: upper bytes beyond size+1 are 0, or copies of bit 8*(size+1)-1 when signext=1.
  - On a write, data_out is unchanged.
- Latency: with req accepted at edge E0, done is high in cycle (size+1)*(RAM_LAT+1)+1 after E0.
  - Example: 4 bytes, RAM_LAT=1 -> cycle 9.
  - Example: 4 bytes, RAM_LAT=0 -> cycle 5.
- Holding and busy:
  - data_out holds until the next read completes.
  - busy=0 only in IDLE.
- req while busy (XFER or DONE) is ignored, not queued. req held high continuously starts a new transfer on the edge after DONE.
- Input changes after acceptance have no effect.
- Arithmetic: the address increment is ADDR_W-bit unsigned with silent wrap; alignment is not required.

Decomposition:
- dshim_pkg holds:
  - state enum (IDLE, XFER, DONE);
  - function lane_sel(i, size, big_endian);
  - function extend(word, size, signext).
- One sub-module, dshim_slot_timer: counts RAM_LAT+1 cycles per slot, outputs slot_last, reloads on slot start, clears on reset.
- Byte steering and assembly stay in dshim_param.

Test Plan:
- Read, defaults. RAM bytes at 0x100..0x103 = 68,45,23,01; req pulse at addr=0x100, size=3.
  -> RAMaddr steps 0x100..0x103, each held 2 cycles with RAMread=1; done in cycle 9; data_out=0x01234568.
- Write, defaults. data_in=0xA1B2C3D4, addr=0x20, size=3, DMemWrite=1.
  -> data_to_RAM D4, C3, B2, A1 at addresses 0x20..0x23; RAMread=0 throughout; data_out unchanged.
- Partial reads. size=0 of byte 0x80: signext=1 -> data_out=0xFFFFFF80; signext=0 -> 0x00000080.
  - size=1, BIG_ENDIAN=1, bytes 12,34 -> 0x00001234.
- Boundary. addr=0xFFFFFFFE, size=3 read.
  -> RAMaddr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
  - With RAM_LAT=0: each slot is 1 cycle and done arrives in cycle 5.
- Ignore and abort.
  - req re-pulsed in XFER and DONE -> ignored, exactly one done.
  - reset asserted mid-XFER -> all outputs 0 immediately, no done, next req completes normally.
- Scaling. WORD_BYTES=8, size=7 read of bytes 01..08.
  -> data_out=0x0807060504030201; busy high for 17 cycles with RAM_LAT=1.
